// File: rtl/log_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_mult_pkg
// Description : Shared types, sizes and the antilog helper for the Mitchell
//               log-domain multiplier back end.
//               Types are sized for the largest supported operand width
//               (16 bits). Narrower instances zero-extend into them.
// Revision    : 1.0 - initial release
// ============================================================================
package log_mult_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int KW        = $clog2(MAX_WIDTH);  // leading-one position width
  localparam int PW        = 2 * MAX_WIDTH;      // product width
  localparam int MAX_KEEP  = MAX_WIDTH - 1;      // widest truncated fraction

  // One operand of one lane, as delivered by the leading-one front end.
  typedef struct packed {
    logic [KW-1:0]       k;
    logic [MAX_KEEP-1:0] x_t;
    logic                zero;
    logic                sign;
  } lane_in_t;

  // Stage-1 result of one lane: normalised exponent and fraction.
  typedef struct packed {
    logic [KW:0]         ke;
    logic [MAX_KEEP-1:0] f;
    logic                z;
    logic                sg;
  } lane_s1_t;

  // Mitchell antilog: 1.F scaled by 2^(ke-keep). The mantissa {1,F} holds
  // keep+1 bits, so the result needs ke+1 bits and always fits in PW.
  function automatic logic [PW-1:0] antilog(
    input logic [KW:0]         ke,
    input logic [MAX_KEEP-1:0] f,
    input logic [KW:0]         keep
  );
    logic [PW-1:0] m;
    m = PW'(f) | (PW'(1) << keep);
    if (ke >= keep) begin
      antilog = m << (ke - keep);
    end else begin
      antilog = m >> (keep - ke);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/log_antilog_lane.sv
`default_nettype none
// ============================================================================
// Module      : log_antilog_lane
// Description : Combinational antilog shifter for one lane. Turns the
//               normalised exponent/fraction pair into the approximate
//               product magnitude; a zero operand forces the result to 0.
// Ports       : ke      - normalised exponent (K plus fraction carry)
//               f       - fraction bits (KEEP_WIDTH valid LSBs)
//               z       - either operand was zero
//               product - approximate magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module log_antilog_lane
  import log_mult_pkg::*;
#(
  parameter int KEEP_WIDTH = 6
) (
  input  logic [KW:0]         ke,
  input  logic [MAX_KEEP-1:0] f,
  input  logic                z,
  output logic [PW-1:0]       product
);

  localparam logic [KW:0] KEEP_V = (KW+1)'(KEEP_WIDTH);

  assign product = z ? '0 : antilog(ke, f, KEEP_V);

endmodule
`default_nettype wire

// File: rtl/log_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : log_mult_pipe
// Description : Multi-lane, 2-stage pipelined Mitchell log-domain multiplier
//               back end with valid/ready flow control, zero handling and an
//               optional signed mode. All lanes share one handshake.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid / in_ready  - input beat handshake
//               k1, k2               - per-lane leading-one positions
//               x1_t, x2_t           - per-lane truncated fractions
//               zero1, zero2         - per-lane operand-is-zero flags
//               sign1, sign2         - per-lane operand signs
//               out_valid / out_ready- output beat handshake
//               product              - per-lane approximate magnitude
//               out_sign             - per-lane product sign
// Revision    : 1.0 - initial release
// ============================================================================
module log_mult_pipe
  import log_mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 6,
  parameter int LANES      = 4,
  parameter int COMP       = 1,
  parameter int SIGNED     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES-1:0][$clog2(WIDTH)-1:0] k1,
  input  logic [LANES-1:0][$clog2(WIDTH)-1:0] k2,
  input  logic [LANES-1:0][KEEP_WIDTH-1:0]    x1_t,
  input  logic [LANES-1:0][KEEP_WIDTH-1:0]    x2_t,
  input  logic [LANES-1:0]                    zero1,
  input  logic [LANES-1:0]                    zero2,
  input  logic [LANES-1:0]                    sign1,
  input  logic [LANES-1:0]                    sign2,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES-1:0][2*WIDTH-1:0]       product,
  output logic [LANES-1:0]                    out_sign
);

  localparam int KWL = $clog2(WIDTH);
  localparam logic [KEEP_WIDTH:0] COMP_V = (KEEP_WIDTH+1)'(COMP);

  logic                       s1_valid;
  logic                       s2_valid;
  logic                       adv2;
  lane_s1_t [LANES-1:0]       s1_d;
  lane_s1_t [LANES-1:0]       s1_q;
  logic [LANES-1:0][PW-1:0]   prod_d;

  // Stage 2 may load when the output slot is empty or draining this cycle;
  // stage 1 may load when it is empty or stage 2 is taking its beat.
  assign adv2      = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv2;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_in_t              a;
    lane_in_t              b;
    logic [KWL:0]          k_sum;
    logic [KEEP_WIDTH:0]   s_sum;

    assign a = '{k: KW'(k1[i]), x_t: MAX_KEEP'(x1_t[i]), zero: zero1[i], sign: sign1[i]};
    assign b = '{k: KW'(k2[i]), x_t: MAX_KEEP'(x2_t[i]), zero: zero2[i], sign: sign2[i]};

    assign k_sum = {1'b0, KWL'(a.k)} + {1'b0, KWL'(b.k)};
    // Fraction sum is deliberately kept to KEEP_WIDTH+1 bits; its MSB is the
    // carry into the exponent.
    assign s_sum = {1'b0, KEEP_WIDTH'(a.x_t)} + {1'b0, KEEP_WIDTH'(b.x_t)} + COMP_V;

    assign s1_d[i] = '{
      ke: (KW+1)'(k_sum + (KWL+1)'(s_sum[KEEP_WIDTH])),
      f:  MAX_KEEP'(s_sum[KEEP_WIDTH-1:0]),
      z:  a.zero | b.zero,
      sg: (SIGNED != 0) ? (a.sign ^ b.sign) : 1'b0
    };

    log_antilog_lane #(
      .KEEP_WIDTH (KEEP_WIDTH)
    ) u_antilog (
      .ke      (s1_q[i].ke),
      .f       (s1_q[i].f),
      .z       (s1_q[i].z),
      .product (prod_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      product  <= '0;
      out_sign <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      // Output registers only change when a new beat moves in, so they hold
      // stable while the consumer stalls.
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          for (int l = 0; l < LANES; l++) begin
            product[l]  <= prod_d[l][2*WIDTH-1:0];
            out_sign[l] <= s1_q[l].sg & ~s1_q[l].z;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
